// File: rtl/usb_kbd_events_if.sv
// Wishbone slave bus bundle for usb_kbd_events.
// master: the bus host (drives address, data and strobes).
// slave:  the event block (returns read data and acknowledge).
interface usb_kbd_events_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_we_i;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic [3:0]  wb_sel_i;
   logic        wb_ack_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/usb_kbd_events.sv
// usb_kbd_events: turns HID keyboard boot reports into a FIFO of key
// release / press / modifier events, read back over a Wishbone slave.
// Optional feature macro: USB_KBD_EVENTS_MOD_EN adds the modifier-change
// state (one extra busy cycle); without it modifier changes make no events.
module usb_kbd_events #(
   parameter int unsigned DEPTH = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   usb_kbd_events_if.slave  wb,
   input  logic             rpt_i,
   input  logic [1:0]       typ_i,
   input  logic [7:0]       mod_i,
   input  logic [7:0]       key1_i,
   input  logic [7:0]       key2_i,
   input  logic [7:0]       key3_i,
   input  logic [7:0]       key4_i,
   output logic             int_o
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CntW = AW + 1;

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StRel  = 3'd1;
   localparam logic [2:0] StPrs  = 3'd2;
   localparam logic [2:0] StMod  = 3'd3;
   localparam logic [2:0] StUpd  = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [1:0]      slot_q, slot_d;
   logic [7:0]      new_key_q [4];
   logic [7:0]      prev_key_q [4];
   logic [7:0]      new_mod_q, prev_mod_q;

   logic [9:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            missed_q, ovf_q, ack_q, int_q;
   logic [31:0]     dat_q, rd_data;

   logic            rpt_kbd, latch, upd, rollover, in_new, in_prev;
   logic [7:0]      prev_sel, new_sel;
   logic            push, push_ok, pop, full, empty, req;
   logic [9:0]      push_data;
   logic [1:0]      reg_sel;
   logic [8:0]      count_ext;
   logic            clr_missed, clr_ovf;
   logic            unused_bits;

   assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_dat_i[29:0]};

   assign rpt_kbd  = rpt_i && (typ_i == 2'd1);
   assign latch    = rpt_kbd && (state_q == StIdle);
   assign prev_sel = prev_key_q[slot_q];
   assign new_sel  = new_key_q[slot_q];

   // Slot membership tests and ErrorRollOver detection on the latched report
   always_comb begin
      in_new   = 1'b0;
      in_prev  = 1'b0;
      rollover = 1'b0;
      for (int j = 0; j < 4; j++) begin
         if (new_key_q[j] == prev_sel) in_new = 1'b1;
         if (prev_key_q[j] == new_sel) in_prev = 1'b1;
         if (new_key_q[j] == 8'h01) rollover = 1'b1;
      end
   end

   // Report sequencer: one candidate event per cycle, in slot order
   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      push      = 1'b0;
      push_data = 10'h000;
      upd       = 1'b0;
      case (state_q)
         StIdle: begin
            if (rpt_kbd) begin
               state_d = StRel;
               slot_d  = 2'd0;
            end
         end
         StRel: begin
            if (slot_q == 2'd0 && rollover) begin
               // Phantom-key report: drop it whole, keep PREV
               state_d = StIdle;
            end else begin
               if (prev_sel != 8'h00 && !in_new) begin
                  push      = 1'b1;
                  push_data = {2'b00, prev_sel};
               end
               if (slot_q == 2'd3) begin
                  state_d = StPrs;
                  slot_d  = 2'd0;
               end else begin
                  slot_d = slot_q + 2'd1;
               end
            end
         end
         StPrs: begin
            if (new_sel != 8'h00 && !in_prev) begin
               push      = 1'b1;
               push_data = {2'b01, new_sel};
            end
            if (slot_q == 2'd3) begin
`ifdef USB_KBD_EVENTS_MOD_EN
               state_d = StMod;
`else
               state_d = StUpd;
`endif
               slot_d  = 2'd0;
            end else begin
               slot_d = slot_q + 2'd1;
            end
         end
`ifdef USB_KBD_EVENTS_MOD_EN
         StMod: begin
            if (new_mod_q != prev_mod_q) begin
               push      = 1'b1;
               push_data = {2'b10, new_mod_q};
            end
            state_d = StUpd;
         end
`endif
         StUpd: begin
            upd     = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Bus decode and FIFO occupancy
   assign req       = wb.wb_cyc_i && wb.wb_stb_i && !ack_q;
   assign reg_sel   = wb.wb_adr_i[3:2];
   assign empty     = (count_q == '0);
   assign full      = (count_q == CntW'(DEPTH));
   assign pop       = req && !wb.wb_we_i && (reg_sel == 2'd1) && !empty;
   // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
   assign push_ok   = push && (!full || pop) && !wb_rst_i;
   assign count_ext = 9'(count_q);
   assign clr_missed = req && wb.wb_we_i && (reg_sel == 2'd0) && wb.wb_dat_i[31];
   assign clr_ovf    = req && wb.wb_we_i && (reg_sel == 2'd0) && wb.wb_dat_i[30];

   // Next FIFO count
   always_comb begin
      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Register read mux
   always_comb begin
      rd_data = 32'h0;
      case (reg_sel)
         2'd0: rd_data = {missed_q, ovf_q, 14'b0, full, empty, 5'b0, count_ext};
         2'd1: rd_data = empty ? 32'h0 : {1'b1, 21'b0, mem[rd_ptr_q]};
         default: rd_data = 32'h0;
      endcase
   end

   // FIFO storage, no reset needed since pointers define validity
   always_ff @(posedge wb_clk_i) begin
      if (push_ok) mem[wr_ptr_q] <= push_data;
   end

   // Sequencer, snapshots, FIFO pointers, flags and bus response
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= StIdle;
         slot_q     <= 2'd0;
         new_key_q  <= '{default: 8'h00};
         prev_key_q <= '{default: 8'h00};
         new_mod_q  <= 8'h00;
         prev_mod_q <= 8'h00;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         missed_q   <= 1'b0;
         ovf_q      <= 1'b0;
         ack_q      <= 1'b0;
         dat_q      <= 32'h0;
         int_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         if (latch) begin
            new_key_q[0] <= key1_i;
            new_key_q[1] <= key2_i;
            new_key_q[2] <= key3_i;
            new_key_q[3] <= key4_i;
            new_mod_q    <= mod_i;
         end
         if (upd) begin
            prev_key_q <= new_key_q;
            prev_mod_q <= new_mod_q;
         end
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q  <= count_d;
         // Sets win over same-cycle clears so no event is silently lost
         missed_q <= (rpt_kbd && state_q != StIdle) || (missed_q && !clr_missed);
         ovf_q    <= (push && full && !pop) || (ovf_q && !clr_ovf);
         ack_q    <= req;
         if (req) dat_q <= wb.wb_we_i ? 32'h0 : rd_data;
         int_q    <= (count_d != '0);
      end
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_dat_o = dat_q;
   assign int_o       = int_q;

endmodule

// File: tb/tb_usb_kbd_events.sv
// Directed bench for usb_kbd_events: stimulus pushes expected bus/interrupt
// results into a queue; a negedge monitor pops and compares them.
module tb_usb_kbd_events;
   logic clk = 1'b0;
   logic rst;
   logic rpt;
   logic [1:0] typ;
   logic [7:0] mod_r, k1, k2, k3, k4;
   logic int_w;

   always #5 clk = ~clk;

   usb_kbd_events_if ifc ();

   usb_kbd_events #(.DEPTH(16)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb       (ifc),
      .rpt_i    (rpt),
      .typ_i    (typ),
      .mod_i    (mod_r),
      .key1_i   (k1),
      .key2_i   (k2),
      .key3_i   (k3),
      .key4_i   (k4),
      .int_o    (int_w)
   );

   // kind 0: bus read compare, 1: bus write (consume only), 2: int_o compare
   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   bit   done = 1'b0;

   // Monitor: compare whatever the DUT presents against the queue head
   always @(negedge clk) begin
      if (ifc.wb_ack_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack=1 want no ack");
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.kind == 0) begin
               checks++;
               if (ifc.wb_dat_o !== mon_e.exp) begin
                  errors++;
                  $display("FAIL %s: got %h want %h", mon_e.name, ifc.wb_dat_o, mon_e.exp);
               end
            end
         end
      end else if (exp_q.size() > 0 && exp_q[0].kind == 2) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (int_w !== mon_e.exp[0]) begin
            errors++;
            $display("FAIL %s: got int_o=%b want %b", mon_e.name, int_w, mon_e.exp[0]);
         end
      end
      if (done) begin
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending want 0", exp_q.size());
         end
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test want end");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic bus(input bit we, input logic [1:0] r, input logic [31:0] wd,
                      input logic [31:0] exp, input string name);
      exp_t e;
      bit   got;
      e.kind = we ? 1 : 0;
      e.exp  = exp;
      e.name = name;
      exp_q.push_back(e);
      ifc.wb_cyc_i = 1'b1;
      ifc.wb_stb_i = 1'b1;
      ifc.wb_we_i  = we;
      ifc.wb_adr_i = {28'h0, r, 2'b00};
      ifc.wb_dat_i = wd;
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ifc.wb_ack_o) begin
            got = 1'b1;
            break;
         end
      end
      ifc.wb_cyc_i = 1'b0;
      ifc.wb_stb_i = 1'b0;
      ifc.wb_we_i  = 1'b0;
      if (!got) begin
         $display("FAIL %s: got no ack want ack", name);
         $fatal(1, "bus timeout");
      end
   endtask

   task automatic rd(input logic [1:0] r, input logic [31:0] exp, input string name);
      bus(1'b0, r, 32'h0, exp, name);
   endtask

   task automatic wr(input logic [1:0] r, input logic [31:0] d, input string name);
      bus(1'b1, r, d, 32'h0, name);
   endtask

   task automatic chk_int(input bit v, input string name);
      exp_t e;
      e.kind = 2;
      e.exp  = {31'h0, v};
      e.name = name;
      exp_q.push_back(e);
      tick();
   endtask

   task automatic pulse(input logic [1:0] t, input logic [7:0] m, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
      rpt   = 1'b1;
      typ   = t;
      mod_r = m;
      k1 = a; k2 = b; k3 = c; k4 = d;
      tick();
      rpt = 1'b0;
   endtask

   task automatic report(input logic [7:0] m, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
      pulse(2'd1, m, a, b, c, d);
      idle(12);
   endtask

   logic [9:0] drain_exp [16];

   initial begin
      rst = 1'b1;
      rpt = 1'b0; typ = 2'd0; mod_r = 8'h0;
      k1 = 8'h0; k2 = 8'h0; k3 = 8'h0; k4 = 8'h0;
      ifc.wb_cyc_i = 1'b0; ifc.wb_stb_i = 1'b0; ifc.wb_we_i = 1'b0;
      ifc.wb_adr_i = 32'h0; ifc.wb_dat_i = 32'h0; ifc.wb_sel_i = 4'hf;
      idle(3);
      rst = 1'b0;
      tick();

      // Reset state
      chk_int(1'b0, "rst_int");
      rd(2'd0, 32'h0000_4000, "rst_status");
      rd(2'd1, 32'h0000_0000, "rst_empty_pop");
      rd(2'd2, 32'h0000_0000, "reg2_zero");
      rd(2'd3, 32'h0000_0000, "reg3_zero");

      // Single press
      report(8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
      chk_int(1'b1, "int_after_press");
      rd(2'd0, 32'h0000_0001, "status_cnt1");
      rd(2'd1, 32'h8000_0104, "press_04");
      chk_int(1'b0, "int_after_pop");
      rd(2'd0, 32'h0000_4000, "status_empty");

      // Non-keyboard report ignored
      pulse(2'd2, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00);
      idle(12);
      rd(2'd0, 32'h0000_4000, "nonkbd_ignored");

      // Release, press and modifier change in order
      report(8'h02, 8'h05, 8'h00, 8'h00, 8'h00);
      rd(2'd1, 32'h8000_0004, "rel_04");
      rd(2'd1, 32'h8000_0105, "press_05");
`ifdef USB_KBD_EVENTS_MOD_EN
      rd(2'd1, 32'h8000_0202, "mod_02");
`endif
      rd(2'd1, 32'h0000_0000, "drained_1");

      // ErrorRollOver discard
      report(8'h02, 8'h04, 8'h00, 8'h00, 8'h00);
      rd(2'd1, 32'h8000_0005, "rel_05");
      rd(2'd1, 32'h8000_0104, "press_04b");
      report(8'h00, 8'h01, 8'h00, 8'h00, 8'h00);
      rd(2'd0, 32'h0000_4000, "rollover_no_events");
      report(8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
      rd(2'd1, 32'h8000_0004, "rel_04_after_rollover");
      rd(2'd1, 32'h0000_0000, "drained_2");

      // Report while busy is missed
      pulse(2'd1, 8'h02, 8'h0a, 8'h00, 8'h00, 8'h00);
      idle(2);
      pulse(2'd1, 8'h02, 8'h0b, 8'h00, 8'h00, 8'h00);
      idle(12);
      rd(2'd0, 32'h8000_0001, "missed_set");
      rd(2'd1, 32'h8000_010a, "press_0a_only");
      wr(2'd0, 32'h8000_0000, "clr_missed");
      rd(2'd0, 32'h0000_4000, "missed_clear");

      // Overflow with no reads
      report(8'h02, 8'h04, 8'h05, 8'h06, 8'h07);
      report(8'h02, 8'h08, 8'h09, 8'h0a, 8'h0b);
      report(8'h02, 8'h04, 8'h05, 8'h06, 8'h07);
      report(8'h02, 8'h08, 8'h09, 8'h0a, 8'h0b);
      report(8'h02, 8'h04, 8'h05, 8'h06, 8'h07);
      rd(2'd0, 32'h4000_8010, "full_ovf");
      wr(2'd0, 32'h4000_0000, "clr_ovf");
      rd(2'd0, 32'h0000_8010, "ovf_clear");

      // Pop in the same cycle as a REL push into a full FIFO
      pulse(2'd1, 8'h02, 8'h00, 8'h05, 8'h06, 8'h07);
      rd(2'd1, 32'h8000_000a, "pop_during_push");
      idle(12);
      rd(2'd0, 32'h0000_8010, "full_no_ovf");

      drain_exp = '{10'h104, 10'h105, 10'h106, 10'h107, 10'h004, 10'h005, 10'h006, 10'h007,
                    10'h108, 10'h109, 10'h10a, 10'h10b, 10'h008, 10'h009, 10'h00a, 10'h004};
      for (int i = 0; i < 16; i++) begin
         rd(2'd1, {1'b1, 21'b0, drain_exp[i]}, $sformatf("drain_%0d", i));
      end
      rd(2'd1, 32'h0000_0000, "drained_3");
      rd(2'd0, 32'h0000_4000, "status_after_drain");
      chk_int(1'b0, "int_after_drain");

      // Reset mid-report aborts and clears PREV
      pulse(2'd1, 8'h02, 8'h11, 8'h12, 8'h13, 8'h14);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle(12);
      rd(2'd0, 32'h0000_4000, "midrpt_reset_empty");
      report(8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
      rd(2'd1, 32'h8000_0104, "press_after_reset");
      rd(2'd1, 32'h0000_0000, "drained_4");

      idle(2);
      done = 1'b1;
      idle(5);
   end
endmodule

// File: doc/usb_kbd_events.md
USB_KBD_EVENTS -- requirements
Module: usb_kbd_events

Interface
REQ-001 Parameter DEPTH, default 16, event FIFO depth in entries; power of two, 4..256.
REQ-002 wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-003 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-004 wb_adr_i  in  32  byte address; only bits [3:2] decoded.
REQ-005 wb_dat_i  in  32 / wb_dat_o  out  32  write / read data.
REQ-006 wb_we_i, wb_stb_i, wb_cyc_i  in  1 each; wb_sel_i  in  4, ignored.
REQ-007 wb_ack_o  out  1  single-cycle acknowledge.
REQ-008 rpt_i  in  1  one-cycle report strobe from HID host, already in wb_clk_i domain.
REQ-009 typ_i  in  2  device type; 2'd1 = keyboard.
REQ-010 mod_i, key1_i, key2_i, key3_i, key4_i  in  8 each  modifier byte and four HID usage codes.
REQ-011 int_o  out  1  registered, high while FIFO non-empty.

Function
REQ-012 On rpt_i=1 with typ_i=1 in IDLE, SHALL latch mod_i/key1..4_i into NEW snapshot; otherwise rpt_i ignored.
REQ-013 rpt_i=1 with typ_i=1 while not IDLE SHALL be dropped and set sticky MISSED flag.
REQ-014 If any latched key equals 8'h01 (ErrorRollOver), report SHALL be discarded: return to IDLE next cycle, PREV unchanged, no events.
REQ-015 FSM: IDLE -> REL (4 cycles, slot i=0..3) -> PRS (4 cycles) -> MOD (1 cycle) -> UPD (1 cycle) -> IDLE; report busy exactly 10 cycles after latch edge.
REQ-016 REL slot i: PREV[i]!=0 and PREV[i] not equal to any NEW[0..3] SHALL push {kind=2'b00, code=PREV[i]}.
REQ-017 PRS slot i: NEW[i]!=0 and NEW[i] not equal to any PREV[0..3] SHALL push {kind=2'b01, code=NEW[i]}.
REQ-018 MOD: NEW mod != PREV mod SHALL push {kind=2'b10, code=NEW mod}.
REQ-019 UPD SHALL copy NEW to PREV; at most one push per cycle; events in slot order.
REQ-020 Push when full SHALL drop the event and set sticky OVF, unless a pop occurs same cycle, then accepted.
REQ-021 Simultaneous push and pop SHALL leave count unchanged.
REQ-022 Register 0 (adr[3:2]=0) read: {MISSED[31], OVF[30], 14'b0, full[15], empty[14], 5'b0, count[8:0]}.
REQ-023 Register 1 read: non-empty -> {valid=1[31], 21'b0, kind[9:8], code[7:0]} and pop; empty -> 32'h0, no state change.
REQ-024 Register 0 write: wb_dat_i[31]=1 clears MISSED, wb_dat_i[30]=1 clears OVF; other writes ignored; write to register 1 ignored but acked.
REQ-025 Registers 2,3 read 32'h0.
REQ-026 wb_ack_o SHALL assert the cycle after wb_cyc_i&wb_stb_i&!wb_ack_o, for exactly one cycle; pop/clear side effects occur once per ack.

Reset
REQ-027 wb_rst_i SHALL set FSM IDLE, FIFO empty (count 0), PREV and NEW all zero, MISSED=OVF=0, wb_ack_o=0, wb_dat_o=0, int_o=0.
REQ-028 Reset mid-report SHALL abort without pushing further events; reset dominates any same-cycle rpt_i or bus access.

Configuration
REQ-029 Macro USB_KBD_EVENTS_MOD_EN defined: MOD state present per REQ-018, busy 10 cycles.
REQ-030 Macro undefined: MOD state removed, busy 9 cycles, modifier changes never produce events; PREV mod still updated.

Verification
REQ-031 Reset, report keys {04,00,00,00} mod 00 -> one event reg1=0x8000_0104; int_o falls after pop.
REQ-032 Then report {05,00,00,00} mod 02 -> reg1 reads 0x8000_0004, 0x8000_0105, 0x8000_0202 (MOD_EN), then 0x0.
REQ-033 Report with key 01 after {04,...} -> no events, count stays 0; next report {00,...} -> release 0x8000_0004.
REQ-034 DEPTH=16, 5 reports toggling 4 distinct keys each without reads -> count=16, full=1, OVF=1; write 0x4000_0000 -> OVF=0.
REQ-035 Second rpt_i 3 cycles after first -> MISSED=1, only first report's events present.
REQ-036 Pop on reg1 in same cycle as REL push with FIFO full -> push accepted, count stays DEPTH, OVF=0.
